// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - Q16.16 sign-magnitude word type, constants and LIF state encoding.
package fixed_pkg;
    localparam int N = 32;
    localparam int Q = 16;

    typedef logic [N-1:0] fixed_t;

    localparam fixed_t FIXED_ONE     = 32'h0001_0000;
    localparam fixed_t FIXED_ZERO    = 32'h0000_0000;
    localparam fixed_t FIXED_NEG_ONE = 32'h8001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAK,
        ST_GAIN,
        ST_SUM,
        ST_FIRE,
        ST_DONE
    } lif_state_t;
endpackage

// File: rtl/add.sv
// rtl/add.sv - sign-magnitude adder; magnitude carry is dropped and zero is always positive.
module add
    import fixed_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    logic [N-2:0] mag;
    logic         sgn;

    always_comb begin
        mag = '0;
        sgn = 1'b0;
        if (a[N-1] == b[N-1]) begin
            mag = a[N-2:0] + b[N-2:0];
            sgn = a[N-1];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            mag = a[N-2:0] - b[N-2:0];
            sgn = a[N-1];
        end else begin
            mag = b[N-2:0] - a[N-2:0];
            sgn = b[N-1];
        end
        y = {sgn & (|mag), mag};
    end
endmodule

// File: rtl/fixed_point_cmp.sv
// rtl/fixed_point_cmp.sv - signed compare of two sign-magnitude words (a >= b).
module fixed_point_cmp
    import fixed_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         a_ge_b
);
    logic signed [N:0] sa;
    logic signed [N:0] sb;

    // Two's complement view makes +0 and -0 compare equal.
    assign sa = a[N-1] ? -$signed({2'b00, a[N-2:0]}) : $signed({2'b00, a[N-2:0]});
    assign sb = b[N-1] ? -$signed({2'b00, b[N-2:0]}) : $signed({2'b00, b[N-2:0]});
    assign a_ge_b = (sa >= sb);
endmodule

// File: rtl/lif_refractory_timer.sv
// rtl/lif_refractory_timer.sv - refractory step counter with load, decrement and active flag.
module lif_refractory_timer #(
    parameter int STEPS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic active
);
    localparam int W = $clog2(STEPS + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(STEPS);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active = (count_q != '0);
endmodule

// File: rtl/mult.sv
// rtl/mult.sv - sign-magnitude multiplier keeping product bits [N-2+Q:Q], truncated.
module mult
    import fixed_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    logic [2*(N-1)-1:0] ext_a;
    logic [2*(N-1)-1:0] ext_b;
    logic [N-2:0]       mag;

    assign ext_a = {{(N-1){1'b0}}, a[N-2:0]};
    assign ext_b = {{(N-1){1'b0}}, b[N-2:0]};
    assign mag   = (N-1)'((ext_a * ext_b) >> Q);
    assign y     = {a[N-1] ^ b[N-1], mag};
endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - multi-cycle LIF neuron update over one shared mult/add pair.
// Define LIF_REFRACTORY_EN to build the refractory counter and ignore-input window.
module lif_neuron
    import fixed_pkg::*;
#(
    parameter fixed_t V_REST       = 32'h0000_0000,
    parameter fixed_t V_TH         = 32'h0001_0000,
    parameter fixed_t V_RESET      = 32'h0000_0000,
    parameter fixed_t LEAK         = 32'h0000_8000,
    parameter fixed_t GAIN         = 32'h0001_0000,
    parameter int     REFRAC_STEPS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] i_syn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] v_out,
    output logic         spike
);
    lif_state_t state_q, state_d;
    fixed_t     i_q, i_d, leak_q, leak_d, gain_q, gain_d;
    fixed_t     acc_q, acc_d, vnext_q, vnext_d, v_q, v_d;
    logic       spike_q, spike_d;

    fixed_t add_a, add_b, add_y, mul_a, mul_b, mul_y;
    logic   th_ge, refr_active, refr_load, refr_dec;

    add             u_add (.a(add_a), .b(add_b), .y(add_y));
    mult            u_mult (.a(mul_a), .b(mul_b), .y(mul_y));
    fixed_point_cmp u_cmp (.a(vnext_q), .b(V_TH), .a_ge_b(th_ge));

`ifdef LIF_REFRACTORY_EN
    lif_refractory_timer #(.STEPS(REFRAC_STEPS)) u_refr (
        .clk(clk), .reset(reset), .load(refr_load), .dec(refr_dec), .active(refr_active)
    );
`else
    localparam int REFRAC_UNUSED = REFRAC_STEPS;
    logic refr_unused;
    assign refr_unused = refr_load ^ refr_dec;
    assign refr_active = 1'b0;
`endif

    // LEAK forms V_REST - v; GAIN forms v + leak term; SUM adds the gain term.
    always_comb begin
        add_a = v_q;
        add_b = leak_q;
        if (state_q == ST_LEAK) begin
            add_a = V_REST;
            add_b = {~v_q[N-1], v_q[N-2:0]};
        end else if (state_q == ST_SUM) begin
            add_a = acc_q;
            add_b = gain_q;
        end
    end

    always_comb begin
        mul_a = GAIN;
        mul_b = i_q;
        if (state_q == ST_LEAK) begin
            mul_a = LEAK;
            mul_b = add_y;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        leak_d    = leak_q;
        gain_d    = gain_q;
        acc_d     = acc_q;
        vnext_d   = vnext_q;
        v_d       = v_q;
        spike_d   = spike_q;
        refr_load = 1'b0;
        refr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                i_d     = i_syn;
                state_d = ST_LEAK;
            end
            ST_LEAK: begin
                leak_d  = mul_y;
                state_d = ST_GAIN;
            end
            ST_GAIN: begin
                gain_d  = mul_y;
                acc_d   = add_y;
                state_d = ST_SUM;
            end
            ST_SUM: begin
                vnext_d = add_y;
                state_d = ST_FIRE;
            end
            ST_FIRE: begin
                state_d = ST_DONE;
                if (refr_active) begin
                    v_d      = V_RESET;
                    spike_d  = 1'b0;
                    refr_dec = 1'b1;
                end else if (th_ge) begin
                    v_d       = V_RESET;
                    spike_d   = 1'b1;
                    refr_load = 1'b1;
                end else begin
                    v_d     = vnext_q;
                    spike_d = 1'b0;
                end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            leak_q  <= '0;
            gain_q  <= '0;
            acc_q   <= '0;
            vnext_q <= '0;
            v_q     <= V_REST;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            leak_q  <= leak_d;
            gain_q  <= gain_d;
            acc_q   <= acc_d;
            vnext_q <= vnext_d;
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign v_out     = v_q;
    assign spike     = spike_q;
endmodule
